// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and digit-adjust helper for the BCD encoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_enc_state_t;

  // Pre-shift correction so a digit of 5..9 carries correctly after doubling.
  function automatic bcd_digit_t add3_if_ge5(bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/priority_index_encoder.sv
// ============================================================================
// Module      : priority_index_encoder
// Description : Combinational priority encoder, lines [NUM_LINES:1] -> index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module priority_index_encoder
  import bcd_pkg::*;
#(
  parameter int NUM_LINES = 99,
  parameter int LOW_WINS  = 0,
  parameter int IDX_W     = $clog2(NUM_LINES + 1)
) (
  input  logic [NUM_LINES:1] lines_in,
  output logic [IDX_W-1:0]   index,
  output logic               any_active
);

  // The last match in scan order wins, so scan direction selects the priority.
  generate
    if (LOW_WINS != 0) begin : g_low_wins
      always_comb begin
        index = '0;
        for (int i = NUM_LINES; i >= 1; i--) begin
          if (lines_in[i]) index = IDX_W'(i);
        end
      end
    end else begin : g_high_wins
      always_comb begin
        index = '0;
        for (int i = 1; i <= NUM_LINES; i++) begin
          if (lines_in[i]) index = IDX_W'(i);
        end
      end
    end
  endgenerate

  assign any_active = |lines_in;

endmodule

`default_nettype wire

// File: rtl/bcd_priority_encoder_seq.sv
// ============================================================================
// Module      : bcd_priority_encoder_seq
// Description : Registered priority encoder with sequential double-dabble BCD.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_priority_encoder_seq
  import bcd_pkg::*;
#(
  parameter int NUM_LINES  = 99,
  parameter int NUM_DIGITS = 2,
  parameter int LOW_WINS   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_LINES:1]      lines_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    none_active
);

  localparam int IDX_W = $clog2(NUM_LINES + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(IDX_W + 1);

  generate
    if (10 ** NUM_DIGITS <= NUM_LINES) begin : g_bad_params
      $error("NUM_DIGITS too small to represent NUM_LINES");
    end
  endgenerate

  bcd_enc_state_t     state_q, state_d;
  logic [IDX_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               none_q, none_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]       win_idx;
  logic                   any_active;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+IDX_W-1:0] shifted;

  priority_index_encoder #(
    .NUM_LINES (NUM_LINES),
    .LOW_WINS  (LOW_WINS),
    .IDX_W     (IDX_W)
  ) u_prio (
    .lines_in   (lines_in),
    .index      (win_idx),
    .any_active (any_active)
  );

  always_comb begin
    adj = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      adj[4*k +: 4] = add3_if_ge5(work_q[4*k +: 4]);
    end
    shifted = {adj, bin_q} << 1;
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    work_d      = work_q;
    bcd_out_d   = bcd_out_q;
    none_d      = none_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = win_idx;
          work_d  = '0;
          none_d  = ~any_active;
          cnt_d   = CNT_W'(IDX_W);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        work_d = shifted[BCD_W+IDX_W-1:IDX_W];
        bin_d  = shifted[IDX_W-1:0];
        cnt_d  = cnt_q - CNT_W'(1);
        // Output register loads only on the final step so partial digits never show.
        if (cnt_q == CNT_W'(1)) begin
          bcd_out_d   = shifted[BCD_W+IDX_W-1:IDX_W];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      work_q      <= '0;
      bcd_out_q   <= '0;
      none_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      bcd_out_q   <= bcd_out_d;
      none_q      <= none_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign bcd_out     = bcd_out_q;
  assign none_active = none_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_priority_encoder_seq.sv
// ============================================================================
// Module      : tb_bcd_priority_encoder_seq
// Description : Directed self-checking bench, three parameter configurations.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_priority_encoder_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [99:1] lines99;
  logic [9:1]  lines9;

  logic       in_ready_hi, out_valid_hi, none_hi;
  logic [7:0] bcd_hi;
  logic       in_ready_lo, out_valid_lo, none_lo;
  logic [7:0] bcd_lo;
  logic       in_ready_9, out_valid_9, none_9;
  logic [3:0] bcd_9;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_priority_encoder_seq #(.NUM_LINES(99), .NUM_DIGITS(2), .LOW_WINS(0)) u_dut_hi (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_hi),
    .lines_in(lines99), .out_valid(out_valid_hi), .out_ready(out_ready),
    .bcd_out(bcd_hi), .none_active(none_hi)
  );

  bcd_priority_encoder_seq #(.NUM_LINES(99), .NUM_DIGITS(2), .LOW_WINS(1)) u_dut_lo (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_lo),
    .lines_in(lines99), .out_valid(out_valid_lo), .out_ready(out_ready),
    .bcd_out(bcd_lo), .none_active(none_lo)
  );

  bcd_priority_encoder_seq #(.NUM_LINES(9), .NUM_DIGITS(1), .LOW_WINS(0)) u_dut_9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_9),
    .lines_in(lines9), .out_valid(out_valid_9), .out_ready(out_ready),
    .bcd_out(bcd_9), .none_active(none_9)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [99:1] l99(input int a, input int b);
    logic [99:1] v;
    v = '0;
    if (a > 0) v[a] = 1'b1;
    if (b > 0) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [9:1] l9(input int a, input int b);
    logic [9:1] v;
    v = '0;
    if (a > 0) v[a] = 1'b1;
    if (b > 0) v[b] = 1'b1;
    return v;
  endfunction

  // One full transaction on all three instances, optional stall in DONE.
  task automatic run_txn(input logic [99:1] v99, input logic [9:1] v9,
                         input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                         input logic [3:0] exp_9, input logic exp_none,
                         input int stall);
    @(negedge clk);
    in_valid  = 1'b1;
    lines99   = v99;
    lines9    = v9;
    out_ready = 1'b0;
    check("in_ready_idle", in_ready_hi, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lines99  = ~v99;
    lines9   = ~v9;
    check("in_ready_busy", in_ready_hi, 0);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      check("latency_hi", out_valid_hi, (n == 7));
      check("latency_9", out_valid_9, (n >= 4));
    end
    check("valid_lo", out_valid_lo, 1);
    check("bcd_hi", bcd_hi, exp_hi);
    check("bcd_lo", bcd_lo, exp_lo);
    check("bcd_9", bcd_9, exp_9);
    check("none_hi", none_hi, exp_none);
    check("none_9", none_9, exp_none);
    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      @(negedge clk);
      check("stall_valid", out_valid_hi, 1);
      check("stall_bcd", bcd_hi, exp_hi);
      check("stall_in_ready", in_ready_hi, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", in_ready_hi, 1);
    check("release_valid", out_valid_hi, 0);
    check("hold_bcd", bcd_hi, exp_hi);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lines99   = '0;
    lines9    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready_hi, 1);
    check("rst_valid", out_valid_hi, 0);
    check("rst_bcd", bcd_hi, 8'h00);
    check("rst_none", none_hi, 0);

    run_txn(l99(42, 7), l9(9, 3), 8'h42, 8'h07, 4'h9, 1'b0, 0);
    run_txn(l99(0, 0),  l9(0, 0), 8'h00, 8'h00, 4'h0, 1'b1, 0);
    run_txn(l99(99, 0), l9(1, 0), 8'h99, 8'h99, 4'h1, 1'b0, 0);
    run_txn(l99(1, 0),  l9(2, 0), 8'h01, 8'h01, 4'h2, 1'b0, 0);
    run_txn('1,         '1,       8'h99, 8'h01, 4'h9, 1'b0, 0);
    run_txn(l99(42, 0), l9(5, 0), 8'h42, 8'h42, 4'h5, 1'b0, 5);

    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("no_extra_accept", out_valid_hi, 0);
    end

    // Abort: reset lands on the third CONVERT edge.
    @(negedge clk);
    in_valid = 1'b1;
    lines99  = l99(58, 13);
    lines9   = l9(7, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready_hi, 1);
    check("abort_valid", out_valid_hi, 0);
    check("abort_bcd_hi", bcd_hi, 8'h00);
    check("abort_bcd_9", bcd_9, 4'h0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid_hi | out_valid_lo | out_valid_9, 0);
    end

    run_txn(l99(58, 13), l9(7, 6), 8'h58, 8'h13, 4'h7, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
